// File: rtl/skew_inbuf_if.sv
// Host-side bundle of the skewed input buffer: push/read/control strobes in,
// per-lane data/valid and status flags out.
interface skew_inbuf_if #(
  parameter int DW    = 8,
  parameter int LANES = 4
);
  logic                write;
  logic [LANES*DW-1:0] din;
  logic                read;
  logic                start;
  logic                flush;
  logic [LANES*DW-1:0] dout;
  logic [LANES-1:0]    dvalid;
  logic [LANES-1:0]    empty;
  logic                full;
  logic                overflow;

  modport master (
    output write, din, read, start, flush,
    input  dout, dvalid, empty, full, overflow
  );

  modport slave (
    input  write, din, read, start, flush,
    output dout, dvalid, empty, full, overflow
  );
endinterface

// File: rtl/skew_inbuf.sv
// Per-lane FIFOs with lane k padding k*SKEW zero slots before its data; one-cycle read latency.
// Writes are dropped (sticky overflow) while any lane is full; read=0 holds the outputs.
module skew_inbuf #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int LANES = 4,
  parameter int SKEW  = 1
) (
  input  logic         clk,
  input  logic         rstn,
  skew_inbuf_if.slave  bus
);
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int PADMAX = (LANES - 1) * SKEW;
  localparam int PW     = (PADMAX < 1) ? 1 : $clog2(PADMAX + 1);

  logic [DW-1:0]       r_mem [LANES][DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr [LANES];
  logic [CW-1:0]       r_cnt  [LANES];
  logic [PW-1:0]       r_pad  [LANES];
  logic [LANES*DW-1:0] r_dout;
  logic [LANES-1:0]    r_dvalid;
  logic                r_overflow;

  logic [LANES-1:0]    w_lane_full;
  logic [LANES-1:0]    w_empty;
  logic [LANES-1:0]    w_pop;
  logic                w_full;
  logic                w_push;

  function automatic logic [PW-1:0] pad_init(input int k);
    return PW'(k * SKEW);
  endfunction

  // A start on a read cycle pops only where the reloaded pad is already zero.
  always_comb begin
    w_lane_full = '0;
    w_empty     = '0;
    w_pop       = '0;
    for (int k = 0; k < LANES; k++) begin
      w_lane_full[k] = (r_cnt[k] == CW'(DEPTH));
      w_empty[k]     = (r_cnt[k] == '0);
      w_pop[k]       = bus.read && !bus.flush && !w_empty[k] &&
                       (bus.start ? (pad_init(k) == '0) : (r_pad[k] == '0));
    end
    w_full = |w_lane_full;
    w_push = bus.write && !w_full && !bus.flush;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int k = 0; k < LANES; k++) begin
        r_mem[k][r_wptr] <= bus.din[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr     <= '0;
      r_dout     <= '0;
      r_dvalid   <= '0;
      r_overflow <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        r_rptr[k] <= '0;
        r_cnt[k]  <= '0;
        r_pad[k]  <= pad_init(k);
      end
    end else if (bus.flush) begin
      r_wptr   <= '0;
      r_dout   <= '0;
      r_dvalid <= '0;
      for (int k = 0; k < LANES; k++) begin
        r_rptr[k] <= '0;
        r_cnt[k]  <= '0;
        r_pad[k]  <= pad_init(k);
      end
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (bus.write && w_full) begin
        r_overflow <= 1'b1;
      end
      for (int k = 0; k < LANES; k++) begin
        r_cnt[k] <= r_cnt[k] + CW'(w_push) - CW'(w_pop[k]);
        if (w_pop[k]) begin
          r_rptr[k] <= r_rptr[k] + AW'(1);
        end
        if (bus.start) begin
          r_pad[k] <= pad_init(k);
        end else if (bus.read && r_pad[k] != '0) begin
          r_pad[k] <= r_pad[k] - PW'(1);
        end
        if (bus.read) begin
          r_dout[k*DW +: DW] <= w_pop[k] ? r_mem[k][r_rptr[k]] : '0;
          r_dvalid[k]        <= w_pop[k];
        end
      end
    end
  end

  assign bus.dout     = r_dout;
  assign bus.dvalid   = r_dvalid;
  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
  assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_skew_inbuf.sv
// Bench for skew_inbuf (DW=8, DEPTH=4, LANES=3, SKEW=1): directed scenarios plus
// a random run compared against a queue-based reference model.
module tb_skew_inbuf;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int L     = 3;
  localparam int SKEW  = 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  skew_inbuf_if #(.DW(DW), .LANES(L)) bus ();

  skew_inbuf #(.DW(DW), .DEPTH(DEPTH), .LANES(L), .SKEW(SKEW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] mq [L][$];
  int         mpad [L];
  logic [7:0] mdout [L];
  bit         mdv [L];
  bit         movf;

  task automatic model_clear();
    for (int k = 0; k < L; k++) begin
      mq[k].delete();
      mpad[k]  = k * SKEW;
      mdout[k] = 8'h0;
      mdv[k]   = 1'b0;
    end
    movf = 1'b0;
  endtask

  task automatic do_reset();
    bus.write = 0; bus.din = '0; bus.read = 0; bus.start = 0; bus.flush = 0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_clear();
  endtask

  // Drive one clock of stimulus (called at a negedge) and advance the model.
  task automatic step(input bit w, input logic [L*DW-1:0] d, input bit r, input bit s, input bit f);
    bit fullm;
    fullm = 1'b0;
    for (int k = 0; k < L; k++) if (mq[k].size() == DEPTH) fullm = 1'b1;
    for (int k = 0; k < L; k++) begin
      if (f) begin
        mq[k].delete(); mpad[k] = k * SKEW; mdout[k] = 8'h0; mdv[k] = 1'b0;
      end else if (r) begin
        if (s ? (k * SKEW == 0) : (mpad[k] == 0)) begin
          if (mq[k].size() > 0) begin mdout[k] = mq[k].pop_front(); mdv[k] = 1'b1; end
          else begin mdout[k] = 8'h0; mdv[k] = 1'b0; end
        end else begin
          mdout[k] = 8'h0; mdv[k] = 1'b0;
          if (!s) mpad[k]--;
        end
      end
      if (!f && s) mpad[k] = k * SKEW;
    end
    if (!f && w) begin
      if (fullm) movf = 1'b1;
      else for (int k = 0; k < L; k++) mq[k].push_back(d[k*DW +: DW]);
    end
    bus.write = w; bus.din = d; bus.read = r; bus.start = s; bus.flush = f;
    @(posedge clk);
    @(negedge clk);
    bus.write = 0; bus.read = 0; bus.start = 0; bus.flush = 0;
  endtask

  function automatic logic [L*DW-1:0] rep(input logic [7:0] v);
    return {L{v}};
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    bus.write = 0; bus.din = '0; bus.read = 0; bus.start = 0; bus.flush = 0;
    #3;
    checks++;
    if (bus.dout !== '0 || bus.dvalid !== '0 || bus.empty !== 3'b111 || bus.full !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: dout=%h dvalid=%b empty=%b full=%b ovf=%b, want 0/0/111/0/0",
               bus.dout, bus.dvalid, bus.empty, bus.full, bus.overflow);
    end
    do_reset();
  endtask

  task automatic test_skew_drain();
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, rep(8'(i)), 0, 0, 0);
    for (int c = 0; c < 7; c++) begin
      step(0, '0, 1, 0, 0);
      for (int k = 0; k < L; k++) begin
        int idx; logic [7:0] ev; bit evld;
        idx  = c - k;
        evld = (idx >= 0 && idx < 4);
        ev   = evld ? 8'(idx + 1) : 8'h0;
        checks++;
        if (bus.dout[k*DW +: DW] !== ev || bus.dvalid[k] !== evld) begin
          errors++;
          $display("FAIL skew_drain c%0d lane%0d: got %0d/%b want %0d/%b",
                   c, k, bus.dout[k*DW +: DW], bus.dvalid[k], ev, evld);
        end
      end
    end
    checks++;
    if (bus.empty !== 3'b111) begin
      errors++; $display("FAIL skew_drain_empty: got %b want 111", bus.empty);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step(1, rep(8'(i)), 0, 0, 0);
      checks++;
      if (bus.full !== (i >= 4) || bus.overflow !== (i == 5)) begin
        errors++;
        $display("FAIL overflow_w%0d: full=%b ovf=%b want %b/%b", i, bus.full, bus.overflow, i >= 4, i == 5);
      end
    end
    for (int c = 0; c < 5; c++) begin
      step(0, '0, 1, 0, 0);
      checks++;
      if (bus.dout[7:0] !== ((c < 4) ? 8'(c + 1) : 8'h0) || bus.dvalid[0] !== (c < 4)) begin
        errors++;
        $display("FAIL overflow_read c%0d: lane0 %0d/%b want %0d/%b", c, bus.dout[7:0], bus.dvalid[0],
                 (c < 4) ? c + 1 : 0, c < 4);
      end
    end
  endtask

  task automatic test_full_rw();
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, rep(8'(i)), 0, 0, 0);
    step(1, rep(8'd9), 1, 0, 0);
    checks++;
    if (bus.overflow !== 1'b1 || bus.full !== 1'b1 || bus.dout[7:0] !== 8'd1 || bus.dvalid !== 3'b001) begin
      errors++;
      $display("FAIL full_rw: ovf=%b full=%b lane0=%0d dvalid=%b want 1/1/1/001",
               bus.overflow, bus.full, bus.dout[7:0], bus.dvalid);
    end
    for (int c = 0; c < 6; c++) step(0, '0, 1, 0, 0);
    checks++;
    if (bus.empty !== 3'b111) begin
      errors++; $display("FAIL full_rw_9_dropped: empty=%b want 111", bus.empty);
    end
  endtask

  task automatic test_empty_rw();
    do_reset();
    step(1, rep(8'd7), 1, 0, 0);
    checks++;
    if (bus.dout[7:0] !== 8'd0 || bus.dvalid[0] !== 1'b0 || bus.empty !== 3'b000) begin
      errors++;
      $display("FAIL empty_rw_first: lane0 %0d/%b empty=%b want 0/0/000", bus.dout[7:0], bus.dvalid[0], bus.empty);
    end
    step(0, '0, 1, 0, 0);
    checks++;
    if (bus.dout[7:0] !== 8'd7 || bus.dvalid[0] !== 1'b1) begin
      errors++;
      $display("FAIL empty_rw_second: lane0 %0d/%b want 7/1", bus.dout[7:0], bus.dvalid[0]);
    end
  endtask

  task automatic test_restart();
    logic [7:0] wv [4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wv[i] = 8'($urandom_range(1, 255));
      step(1, rep(wv[i]), 0, 0, 0);
    end
    for (int c = 0; c < 3; c++) step(0, '0, 1, 0, 0);
    step(0, '0, 0, 1, 0);
    for (int c = 0; c < 3; c++) begin
      step(0, '0, 1, 0, 0);
      checks++;
      if (bus.dvalid[2] !== (c == 2) || bus.dout[23:16] !== ((c == 2) ? wv[1] : 8'h0)) begin
        errors++;
        $display("FAIL restart_lane2 c%0d: %0d/%b want %0d/%b", c, bus.dout[23:16], bus.dvalid[2],
                 (c == 2) ? wv[1] : 8'h0, c == 2);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (bus.dout[k*DW +: DW] !== mdout[k] || bus.dvalid[k] !== mdv[k]) begin
          errors++;
          $display("FAIL restart_lane%0d c%0d: %0d/%b want %0d/%b", k, c,
                   bus.dout[k*DW +: DW], bus.dvalid[k], mdout[k], mdv[k]);
        end
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 1; i <= 5; i++) step(1, rep(8'(i)), 0, 0, 0);
    step(0, '0, 1, 0, 0);
    step(1, rep(8'h55), 1, 0, 1);
    checks++;
    if (bus.empty !== 3'b111 || bus.dout !== '0 || bus.dvalid !== '0 || bus.overflow !== 1'b1 || bus.full !== 1'b0) begin
      errors++;
      $display("FAIL flush: empty=%b dout=%h dvalid=%b ovf=%b full=%b want 111/0/0/1/0",
               bus.empty, bus.dout, bus.dvalid, bus.overflow, bus.full);
    end
    step(1, rep(8'h21), 0, 0, 0);
    step(0, '0, 1, 0, 0);
    checks++;
    if (bus.dout[7:0] !== 8'h21 || bus.dvalid !== 3'b001) begin
      errors++;
      $display("FAIL flush_reload: lane0=%h dvalid=%b want 21/001", bus.dout[7:0], bus.dvalid);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [L*DW-1:0] d;
      logic [L-1:0] eemp;
      bit efull;
      d = {8'($urandom), 8'($urandom), 8'($urandom)};
      step($urandom_range(0, 99) < 55, d, $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 3);
      efull = 1'b0;
      for (int k = 0; k < L; k++) begin
        eemp[k] = (mq[k].size() == 0);
        if (mq[k].size() == DEPTH) efull = 1'b1;
        checks++;
        if (bus.dout[k*DW +: DW] !== mdout[k] || bus.dvalid[k] !== mdv[k]) begin
          errors++;
          $display("FAIL random_data c%0d lane%0d: %h/%b want %h/%b", c, k,
                   bus.dout[k*DW +: DW], bus.dvalid[k], mdout[k], mdv[k]);
        end
      end
      checks++;
      if (bus.empty !== eemp || bus.full !== efull || bus.overflow !== movf) begin
        errors++;
        $display("FAIL random_flags c%0d: empty=%b full=%b ovf=%b want %b/%b/%b", c,
                 bus.empty, bus.full, bus.overflow, eemp, efull, movf);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 1; i <= 5; i++) step(1, rep(8'(i)), 0, 0, 0);
    step(0, '0, 1, 0, 0);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (bus.dout !== '0 || bus.dvalid !== '0 || bus.empty !== 3'b111 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: dout=%h dvalid=%b empty=%b ovf=%b want 0/0/111/0",
               bus.dout, bus.dvalid, bus.empty, bus.overflow);
    end
    @(negedge clk);
    rstn = 1'b1;
    model_clear();
  endtask

  initial begin
    test_reset();
    test_skew_drain();
    test_overflow();
    test_full_rw();
    test_empty_rw();
    test_restart();
    test_flush();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
